ddr_deserializer: RTL and testbench
===================================

Name: ddr_deserializer

Overview:
Downstream consumer of the dual-edge capture path. Samples a serial input on both clock edges, so it takes two bits per clk cycle. It assembles these bits MSB-first into WIDTH-bit words and presents each word on a valid/ready output handshake. Output logic runs in the posedge domain; only one falling-edge capture register exists.

Parameters:
WIDTH, 8, output word width in bits; must be even and >= 4.

Ports:
clk  input  1  single clock; both edges are used for data sampling.
reset  input  1  synchronous, active-high reset.
din  input  1  serial data, one bit per clock edge.
en  input  1  pair enable, sampled at posedge; when high, the current bit pair is shifted in.
align  input  1  word-boundary resync, sampled at posedge.
word_ready  input  1  downstream accepts word_out when high together with word_valid at a posedge.
word_out  output  WIDTH  assembled word.
word_valid  output  1  word_out holds an unaccepted word.
overflow  output  1  sticky flag: a completed word was dropped.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset.
- Falling-edge register f_cap: f_cap <= din at every negedge; f_cap <= 0 at a negedge while reset is high.
- Pair definition: at each posedge the pair is (f, r). f = f_cap, the bit sampled at the preceding negedge, which is earlier in time. r = din sampled at this posedge. f is the more significant bit of the pair.
- State registers: shift register sh[WIDTH-3:0]; pair counter cnt counting 0..WIDTH/2-1.
- Priority at each posedge: reset > align > en.
- reset high:
  - cnt = 0, sh = 0, word_out = 0, word_valid = 0, overflow = 0.
  - Partial word is discarded.
- align high:
  - cnt = 0, sh = 0; the current pair is discarded.
  - word_out, word_valid and overflow are unaffected; handshake acceptance still applies.
- en low (no align): cnt and sh hold; f_cap keeps sampling.
- en high with cnt < WIDTH/2-1: sh <= {sh[WIDTH-5:0], f, r}; cnt++.
- en high with cnt == WIDTH/2-1 (completion): new_word = {sh, f, r}; cnt <= 0.
- Acceptance: when word_valid && word_ready at a posedge, the held word is consumed.
- Completion handling at that posedge:
  - If word_valid == 0, or the held word is being accepted this edge: word_out <= new_word, word_valid <= 1.
  - Otherwise (word_valid && !word_ready): new_word is dropped, word_out is retained, overflow <= 1.
- Acceptance without completion: word_valid <= 0; word_out holds its last value.
- Latency: word_out and word_valid update at the posedge that samples the final r bit. This is 0 cycles after the last bit edge, registered.
- word_valid stays high until accepted. word_out is stable while word_valid is high.
- Sustained throughput: one word per WIDTH/2 enabled cycles.
- overflow clears only on reset.
- cnt wraps to 0 after completion, including when the word is dropped.

Test Plan:
1. WIDTH=8, word_ready=1, en=1. Pairs (f,r) = (1,0),(1,1),(0,0),(1,0) -> word_out=8'hB2, word_valid high for exactly 1 cycle, overflow=0.
2. Back-to-back words 8'hB2 then 8'h5C with word_ready=1 -> two valid pulses 4 cycles apart, values 8'hB2 then 8'h5C.
3. Stall: word_ready=0 through completion of 8'hA5 and a second word 8'h3C -> word_out stays 8'hA5 with valid high, overflow=1. Raise ready: 8'hA5 is accepted, valid drops, overflow remains 1.
4. Simultaneous accept and completion: valid=1 holding 8'h11, ready=1 on the edge completing 8'h22 -> word_out=8'h22, valid stays 1, overflow=0.
5. en gaps and align: deassert en for 3 cycles mid-word -> same word value results. Pulse align after 2 pairs, then send 4 pairs of 8'hC3 -> word_out=8'hC3.
6. Reset mid-word after 2 pairs while valid=1 -> all outputs 0 on the next posedge. A following 4-pair word 8'h96 is captured correctly.

Source files
------------

// File: rtl/ddr_deserializer.sv
// rtl/ddr_deserializer.sv - dual-edge serial capture, MSB-first word assembly, valid/ready output
module ddr_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             en,
    input  logic             align,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overflow
);
    localparam int NPAIR = WIDTH / 2;
    localparam int CW    = $clog2(NPAIR);

    logic             f_cap_q;
    logic [WIDTH-3:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] shifted;
    logic             cnt_last;

    // Only falling-edge state: the earlier, more significant bit of each pair.
    always_ff @(negedge clk) begin
        if (reset) begin
            f_cap_q <= 1'b0;
        end else begin
            f_cap_q <= din;
        end
    end

    assign shifted  = {sh_q, f_cap_q, din};
    assign cnt_last = (cnt_q == CW'(NPAIR - 1));

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = valid_q && !word_ready;
        ovf_d   = ovf_q;
        if (align) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (en) begin
            if (cnt_last) begin
                sh_d  = '0;
                cnt_d = '0;
                // A held word being accepted this edge frees the slot for the new one.
                if (!valid_q || word_ready) begin
                    word_d  = shifted;
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                sh_d  = shifted[WIDTH-3:0];
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_ddr_deserializer.sv
// tb/tb_ddr_deserializer.sv - self-checking bench for ddr_deserializer
module tb_ddr_deserializer;
    logic       clk = 1'b0;
    logic       reset, din, en, align, word_ready;
    logic [7:0] word_out;
    logic       word_valid, overflow;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    bit         count_en = 1'b0;
    int         vcount = 0;

    typedef struct {
        logic [7:0] word_in;
        logic [7:0] exp_word;
        logic       exp_valid;
        logic       exp_ovf;
    } vec_t;
    vec_t tbl[5];

    ddr_deserializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .en         (en),
        .align      (align),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a handshake is due at the next posedge whenever valid && ready now.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (count_en) vcount++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", {24'd0, word_out}, 32'hFFFF_FFFF);
            end else begin
                check("sb_word", {24'd0, word_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; the posedge inside the task samples r, en and align.
    task automatic pair(input logic f, input logic r, input logic e, input logic a);
        din = f; en = e; align = a;
        @(negedge clk); #1 din = r;
        @(posedge clk); #1;
        en = 1'b0; align = 1'b0;
    endtask

    task automatic send_pairs(input logic [7:0] w, input int n);
        for (int i = 3; i > 3 - n; i--) pair(w[2*i+1], w[2*i], 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pair(1'($urandom), 1'($urandom), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'hB2, 8'hB2, 1'b1, 1'b0};
        tbl[1] = '{8'h5C, 8'h5C, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'hA5, 8'hA5, 1'b1, 1'b0};

        reset = 1'b1; din = 1'b1; en = 1'b1; align = 1'b0; word_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("reset_word", {24'd0, word_out}, 32'h0);
        check("reset_valid", {31'd0, word_valid}, 32'h0);
        check("reset_ovf", {31'd0, overflow}, 32'h0);
        reset = 1'b0; en = 1'b0;

        // Single word, valid high for exactly one cycle.
        exp_q.push_back(8'hB2);
        send_pairs(8'hB2, 4);
        check("t1_word", {24'd0, word_out}, 32'hB2);
        check("t1_valid", {31'd0, word_valid}, 32'h1);
        idle(1);
        check("t1_valid_drop", {31'd0, word_valid}, 32'h0);
        check("t1_ovf", {31'd0, overflow}, 32'h0);

        // Back-to-back words from the table: one valid pulse per 4 cycles.
        vcount = 0; count_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tbl[i].word_in);
            send_pairs(tbl[i].word_in, 4);
            check($sformatf("tbl%0d_word", i), {24'd0, word_out}, {24'd0, tbl[i].exp_word});
            check($sformatf("tbl%0d_valid", i), {31'd0, word_valid}, {31'd0, tbl[i].exp_valid});
            check($sformatf("tbl%0d_ovf", i), {31'd0, overflow}, {31'd0, tbl[i].exp_ovf});
        end
        idle(1);
        count_en = 1'b0;
        check("b2b_pulses", vcount, 5);

        // Stall: second word dropped, first held, overflow sticky.
        word_ready = 1'b0;
        send_pairs(8'hA5, 4);
        send_pairs(8'h3C, 4);
        check("t3_word_held", {24'd0, word_out}, 32'hA5);
        check("t3_valid", {31'd0, word_valid}, 32'h1);
        check("t3_ovf", {31'd0, overflow}, 32'h1);
        exp_q.push_back(8'hA5);
        word_ready = 1'b1;
        idle(1);
        check("t3_valid_drop", {31'd0, word_valid}, 32'h0);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'h1);
        idle(2);
        check("t3_ovf_sticky2", {31'd0, overflow}, 32'h1);

        // Accept and completion on the same edge.
        do_reset();
        check("t4_ovf_cleared", {31'd0, overflow}, 32'h0);
        word_ready = 1'b0;
        send_pairs(8'h11, 4);
        send_pairs(8'h22, 3);
        exp_q.push_back(8'h11);
        word_ready = 1'b1;
        pair(1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(8'h22);
        check("t4_word", {24'd0, word_out}, 32'h22);
        check("t4_valid", {31'd0, word_valid}, 32'h1);
        check("t4_ovf", {31'd0, overflow}, 32'h0);
        idle(1);

        // En gaps mid-word do not disturb assembly.
        exp_q.push_back(8'h69);
        send_pairs(8'h69, 2);
        idle(3);
        pair(1'b1, 1'b0, 1'b1, 1'b0);
        pair(1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_gap_word", {24'd0, word_out}, 32'h69);
        check("t5_gap_valid", {31'd0, word_valid}, 32'h1);
        idle(1);

        // Align after two pairs discards the partial word and its own pair.
        send_pairs(8'hFF, 2);
        pair(1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_align_novalid", {31'd0, word_valid}, 32'h0);
        exp_q.push_back(8'hC3);
        send_pairs(8'hC3, 4);
        check("t5_align_word", {24'd0, word_out}, 32'hC3);
        check("t5_align_valid", {31'd0, word_valid}, 32'h1);
        idle(1);

        // Reset mid-word while a word is held.
        word_ready = 1'b0;
        send_pairs(8'h5A, 4);
        send_pairs(8'hE7, 2);
        check("t6_pre_valid", {31'd0, word_valid}, 32'h1);
        do_reset();
        check("t6_word", {24'd0, word_out}, 32'h0);
        check("t6_valid", {31'd0, word_valid}, 32'h0);
        check("t6_ovf", {31'd0, overflow}, 32'h0);
        word_ready = 1'b1;
        exp_q.push_back(8'h96);
        send_pairs(8'h96, 4);
        check("t6_new_word", {24'd0, word_out}, 32'h96);
        check("t6_new_valid", {31'd0, word_valid}, 32'h1);
        idle(2);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
